pool2x2_relu: RTL
=================

POOL2X2_RELU -- requirements
Module: pool2x2_relu

Interface
REQ-001 Parameter DATA_W, default 32, scratchpad word width; all arithmetic is signed two's complement at this width.
REQ-002 Parameter ADDR_W, default 8, scratchpad address width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin a pooling pass; sampled only in IDLE.
REQ-006 base_in  input  ADDR_W  base address of the convolution output tile in the source scratchpad.
REQ-007 base_out  input  ADDR_W  base address of the pooled result in the destination scratchpad.
REQ-008 in_w, in_h  input  5 each  source tile width and height in words (conv output dimensions).
REQ-009 relu_en  input  1  1 = clamp negative results to 0 before writing.
REQ-010 busy, done  output  1 each  pass in progress; one-cycle completion pulse.
REQ-011 i_en, i_we  output  1 each; i_addr  output  ADDR_W; i_di  output  DATA_W; i_dout  input  DATA_W  source scratchpad port (single-port, synchronous read, 1-cycle latency).
REQ-012 o_en, o_we  output  1 each; o_addr  output  ADDR_W; o_di  output  DATA_W; o_dout  input  DATA_W (unused)  destination scratchpad port.

Function
REQ-013 base_in, base_out, in_w, in_h and relu_en SHALL be latched on the edge that accepts start; later input changes do not affect the pass.
REQ-014 Output dimensions: OW = floor(in_w/2), OH = floor(in_h/2); an odd last row or column is ignored.
REQ-015 Outputs are produced in row-major order (oy outer, ox inner).
REQ-016 Per output, reads occur in order (dy,dx) = (0,0),(0,1),(1,0),(1,1) at i_addr = base_in + (2*oy+dy)*in_w + 2*ox+dx, modulo 2^ADDR_W.
REQ-017 States: IDLE, RD0, RD1, RD2, RD3, CAP, WR, DONE; per output RD0->RD1->RD2->RD3->CAP->WR, i.e. exactly 6 cycles per output.
REQ-018 In RDk: i_en=1, i_addr per REQ-016; the data returned in the following cycle is folded into a running signed maximum (first word initialises it).
REQ-019 In CAP: i_en=0; the fourth word is folded in.
REQ-020 In WR: o_en=1, o_we=1, o_addr = base_out + oy*OW + ox (mod 2^ADDR_W), o_di = relu_en ? max(result,0) : result.
REQ-021 After WR: next output -> RD0; after the last output -> DONE.
REQ-022 DONE: done=1 for exactly one cycle, busy=0; next state IDLE.
REQ-023 busy=1 in every state except IDLE and DONE.
REQ-024 OW=0 or OH=0 (in_w<2 or in_h<2): IDLE -> DONE directly, no scratchpad access.
REQ-025 start while not in IDLE SHALL be ignored; start during DONE SHALL be ignored.
REQ-026 i_we and i_di SHALL be constant 0; i_en=0 and o_en=o_we=0 outside the states above.
REQ-027 done SHALL rise exactly 6*OW*OH+1 cycles after the start-accepting edge.

Reset
REQ-028 While reset=0: state IDLE, busy=0, done=0, i_en=0, o_en=0, o_we=0, all address/data outputs 0, latched parameters and running maximum cleared.
REQ-029 Reset assertion mid-pass SHALL abort immediately with no further writes; after release the block waits for a new start.

Verification
REQ-030 4x4 source 0..15, relu_en=0 -> writes 5,7,13,15 at base_out+0..3; done 25 cycles after start.
REQ-031 5x5 source 0..24 (odd edge) -> writes 6,8,16,18; row 4 and column 4 never read.
REQ-032 4x4 source all 0xFFFFFFFF (-1): relu_en=0 -> four writes of 0xFFFFFFFF; relu_en=1 -> four writes of 0.
REQ-033 in_w=1, in_h=5, start -> no i_en/o_we activity, done pulse on the 2nd edge after start.
REQ-034 base_in=254, in_w=in_h=2, source words at 254,255,0,1 = 3,9,-4,2 -> single write of 9; second start pulse issued at cycle 3 ignored.
REQ-035 reset=0 asserted during the 2nd output of a 4x4 pass -> outputs zero, exactly one write recorded; a new start then completes a full pass.

Source files
------------

// File: rtl/pool2x2_relu.sv
// 2x2 max-pooling engine with optional ReLU.
// Reads a conv output tile from a source scratchpad with 1-cycle read latency,
// reduces each 2x2 window to its signed maximum and writes one word per window
// to a destination scratchpad in row-major order.
module pool2x2_relu #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_in,
    input  logic [ADDR_W-1:0] base_out,
    input  logic [4:0]        in_w,
    input  logic [4:0]        in_h,
    input  logic              relu_en,
    output logic              busy,
    output logic              done,
    output logic              i_en,
    output logic              i_we,
    output logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_di,
    input  logic [DATA_W-1:0] i_dout,
    output logic              o_en,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_di,
    input  logic [DATA_W-1:0] o_dout
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_RD3  = 3'd4,
        S_CAP  = 3'd5,
        S_WR   = 3'd6,
        S_DONE = 3'd7
    } state_t;

    state_t              state_r;
    logic [ADDR_W-1:0]   base_in_r;
    logic [ADDR_W-1:0]   base_out_r;
    logic [4:0]          in_w_r;
    logic                relu_r;
    logic [3:0]          ow_r;
    logic [3:0]          oh_r;
    logic [3:0]          ox_r;
    logic [3:0]          oy_r;
    logic [DATA_W-1:0]   max_r;
    logic                busy_r;
    logic                done_r;
    logic                i_en_r;
    logic [ADDR_W-1:0]   i_addr_r;
    logic                o_en_r;
    logic [ADDR_W-1:0]   o_addr_r;
    logic [DATA_W-1:0]   o_di_r;
    logic                unused_s;

    // Source word address of window (ox,oy), tap (dy,dx); wraps mod 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] rd_addr(
        input logic [ADDR_W-1:0] base,
        input logic [4:0]        w,
        input logic [3:0]        ox,
        input logic [3:0]        oy,
        input logic              dy,
        input logic              dx
    );
        return base + ADDR_W'({oy, dy}) * ADDR_W'(w) + ADDR_W'({ox, dx});
    endfunction

    // Signed maximum of two words.
    function automatic logic [DATA_W-1:0] smax(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        if ($signed(a) > $signed(b)) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    // Clamp negative values to zero when enabled.
    function automatic logic [DATA_W-1:0] relu(
        input logic [DATA_W-1:0] v,
        input logic              en
    );
        if (en && v[DATA_W-1]) begin
            return {DATA_W{1'b0}};
        end else begin
            return v;
        end
    endfunction

    // Sequencer: state, latched pass parameters, running max and all outputs.
    // Port outputs are loaded together with the state they belong to, so they
    // are valid for exactly the cycles the FSM spends in that state; done is
    // issued the cycle after DONE so that start is also locked out during it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= S_IDLE;
            base_in_r  <= {ADDR_W{1'b0}};
            base_out_r <= {ADDR_W{1'b0}};
            in_w_r     <= 5'd0;
            relu_r     <= 1'b0;
            ow_r       <= 4'd0;
            oh_r       <= 4'd0;
            ox_r       <= 4'd0;
            oy_r       <= 4'd0;
            max_r      <= {DATA_W{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            i_en_r     <= 1'b0;
            i_addr_r   <= {ADDR_W{1'b0}};
            o_en_r     <= 1'b0;
            o_addr_r   <= {ADDR_W{1'b0}};
            o_di_r     <= {DATA_W{1'b0}};
        end else begin
            i_en_r <= 1'b0;
            o_en_r <= 1'b0;
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start && !done_r) begin
                        base_in_r  <= base_in;
                        base_out_r <= base_out;
                        in_w_r     <= in_w;
                        relu_r     <= relu_en;
                        ow_r       <= in_w[4:1];
                        oh_r       <= in_h[4:1];
                        ox_r       <= 4'd0;
                        oy_r       <= 4'd0;
                        max_r      <= {DATA_W{1'b0}};
                        if ((in_w[4:1] == 4'd0) || (in_h[4:1] == 4'd0)) begin
                            state_r <= S_DONE;
                            busy_r  <= 1'b0;
                        end else begin
                            state_r  <= S_RD0;
                            busy_r   <= 1'b1;
                            i_en_r   <= 1'b1;
                            i_addr_r <= rd_addr(base_in, in_w, 4'd0, 4'd0, 1'b0, 1'b0);
                        end
                    end else begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                S_RD0: begin
                    state_r  <= S_RD1;
                    i_en_r   <= 1'b1;
                    i_addr_r <= rd_addr(base_in_r, in_w_r, ox_r, oy_r, 1'b0, 1'b1);
                end
                S_RD1: begin
                    // First word of the window seeds the running maximum.
                    max_r    <= i_dout;
                    state_r  <= S_RD2;
                    i_en_r   <= 1'b1;
                    i_addr_r <= rd_addr(base_in_r, in_w_r, ox_r, oy_r, 1'b1, 1'b0);
                end
                S_RD2: begin
                    max_r    <= smax(i_dout, max_r);
                    state_r  <= S_RD3;
                    i_en_r   <= 1'b1;
                    i_addr_r <= rd_addr(base_in_r, in_w_r, ox_r, oy_r, 1'b1, 1'b1);
                end
                S_RD3: begin
                    max_r   <= smax(i_dout, max_r);
                    state_r <= S_CAP;
                end
                S_CAP: begin
                    // Fourth word arrives now; the write word is formed directly.
                    max_r    <= smax(i_dout, max_r);
                    o_di_r   <= relu(smax(i_dout, max_r), relu_r);
                    o_addr_r <= base_out_r + ADDR_W'(oy_r) * ADDR_W'(ow_r) + ADDR_W'(ox_r);
                    o_en_r   <= 1'b1;
                    state_r  <= S_WR;
                end
                S_WR: begin
                    if ((ox_r == ow_r - 4'd1) && (oy_r == oh_r - 4'd1)) begin
                        state_r <= S_DONE;
                        busy_r  <= 1'b0;
                    end else if (ox_r == ow_r - 4'd1) begin
                        ox_r     <= 4'd0;
                        oy_r     <= oy_r + 4'd1;
                        state_r  <= S_RD0;
                        i_en_r   <= 1'b1;
                        i_addr_r <= rd_addr(base_in_r, in_w_r, 4'd0, oy_r + 4'd1, 1'b0, 1'b0);
                    end else begin
                        ox_r     <= ox_r + 4'd1;
                        state_r  <= S_RD0;
                        i_en_r   <= 1'b1;
                        i_addr_r <= rd_addr(base_in_r, in_w_r, ox_r + 4'd1, oy_r, 1'b0, 1'b0);
                    end
                end
                S_DONE: begin
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign i_en     = i_en_r;
    assign i_we     = 1'b0;
    assign i_addr   = i_addr_r;
    assign i_di     = {DATA_W{1'b0}};
    assign o_en     = o_en_r;
    assign o_we     = o_en_r;
    assign o_addr   = o_addr_r;
    assign o_di     = o_di_r;
    // Destination read data is never consumed.
    assign unused_s = ^o_dout;

endmodule
